psram_test_seq: RTL and testbench

- Parametrised write/read-back test sequencer that sits between the top level and the PSRAM `memory` controller.
- Drives the controller's addr / read_strb / write_strb / data_in.
- Write phase: fills 2^DEPTH_LOG2 words at BASE_ADDR with a selectable pattern. Read phase: reads them back and compares.
- Reports pass/fail, error count, first failing location and controller-hang timeout; optionally loops forever.

---
 rtl/psram_test_pkg.sv | 30 +++
 rtl/psram_pattern_gen.sv | 56 +++++
 rtl/psram_test_seq.sv | 228 ++++++++++++++++++++++
 tb/tb_psram_test_seq.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psram_test_pkg.sv
// rtl/psram_test_pkg.sv - shared types and constants for the PSRAM write/read-back test sequencer
package psram_test_pkg;

    // Sequencer states: one request/accept/complete triple per word in each phase
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_ISSUE,
        ST_WR_ACC,
        ST_WR_CPL,
        ST_RD_ISSUE,
        ST_RD_ACC,
        ST_RD_CPL,
        ST_CHECK,
        ST_FINISH
    } state_e;

    // pattern_sel encodings
    localparam logic [1:0] PAT_ADDR = 2'd0;
    localparam logic [1:0] PAT_INV  = 2'd1;
    localparam logic [1:0] PAT_WALK = 2'd2;
    localparam logic [1:0] PAT_LFSR = 2'd3;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/psram_pattern_gen.sv
// rtl/psram_pattern_gen.sv - expected-data generator shared by the write and read phases
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   pattern_sel_i       latched pattern selection
//   index_i             word index within the pass
//   addr_i              current memory word address
//   lfsr_step_i         advance the LFSR by one word
//   lfsr_reseed_i       reload LFSR_SEED (wins over step)
//   expected_o          data word for the current index
module psram_pattern_gen
    import psram_test_pkg::*;
#(
    parameter int          ADDR_W     = 24,
    parameter int          DATA_W     = 16,
    parameter int          DEPTH_LOG2 = 4,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            pattern_sel_i,
    input  logic [DEPTH_LOG2-1:0] index_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic                  lfsr_step_i,
    input  logic                  lfsr_reseed_i,
    output logic [DATA_W-1:0]     expected_o
);

    logic [15:0]       lfsr_q;
    logic [DATA_W-1:0] addr_ext;
    logic [DATA_W-1:0] walk;
    logic [31:0]       shamt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else if (lfsr_reseed_i) begin
            lfsr_q <= LFSR_SEED;
        end else if (lfsr_step_i) begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    always_comb begin
        addr_ext = DATA_W'(addr_i);
        shamt    = 32'(index_i) % 32'(DATA_W);
        walk     = DATA_W'(1) << shamt;
        case (pattern_sel_i)
            PAT_ADDR: expected_o = addr_ext;
            PAT_INV:  expected_o = ~addr_ext;
            PAT_WALK: expected_o = walk;
            default:  expected_o = DATA_W'(lfsr_q);
        endcase
    end

endmodule

// File: rtl/psram_test_seq.sv
// rtl/psram_test_seq.sv - PSRAM write/read-back test sequencer
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   start, loop, pattern_sel   pass control
//   mem_ready, mem_data_out    controller status and read data
//   mem_addr, mem_read_strb,
//   mem_write_strb, mem_data_in  controller request interface
//   busy, done, pass, timeout  pass status
//   err_count, first_err_addr,
//   first_err_data, pass_count  result counters
module psram_test_seq
    import psram_test_pkg::*;
#(
    parameter int                ADDR_W     = 24,
    parameter int                DATA_W     = 16,
    parameter int                DEPTH_LOG2 = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter logic [15:0]       LFSR_SEED  = 16'hACE1,
    parameter int                TIMEOUT    = 4095
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              loop,
    input  logic [1:0]        pattern_sel,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read_strb,
    output logic              mem_write_strb,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data,
    output logic [15:0]       pass_count
);

    localparam int                    TW       = $clog2(TIMEOUT + 1);
    localparam logic [DEPTH_LOG2-1:0] LAST_IDX = '1;

    state_e                state_q, state_d;
    logic [DEPTH_LOG2-1:0] index_q, index_d;
    logic [1:0]            pat_q, pat_d;
    logic [TW-1:0]         wait_q, wait_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  pass_err_q, pass_err_d;
    logic                  pass_q, pass_d;
    logic                  timeout_q, timeout_d;
    logic [15:0]           err_count_q, err_count_d;
    logic [15:0]           pass_count_q, pass_count_d;
    logic [ADDR_W-1:0]     ferr_addr_q, ferr_addr_d;
    logic [DATA_W-1:0]     ferr_data_q, ferr_data_d;
    logic                  lfsr_step, lfsr_reseed;
    logic                  waiting, progress;
    logic [ADDR_W-1:0]     cur_addr;
    logic [DATA_W-1:0]     expected;

    assign cur_addr = BASE_ADDR + ADDR_W'(index_q);

    psram_pattern_gen #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2),
        .LFSR_SEED  (LFSR_SEED)
    ) u_gen (
        .clk           (clk),
        .reset         (reset),
        .pattern_sel_i (pat_q),
        .index_i       (index_q),
        .addr_i        (cur_addr),
        .lfsr_step_i   (lfsr_step),
        .lfsr_reseed_i (lfsr_reseed),
        .expected_o    (expected)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            index_q      <= '0;
            pat_q        <= PAT_ADDR;
            wait_q       <= '0;
            rdata_q      <= '0;
            pass_err_q   <= 1'b0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
            err_count_q  <= '0;
            pass_count_q <= '0;
            ferr_addr_q  <= '0;
            ferr_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            pat_q        <= pat_d;
            wait_q       <= wait_d;
            rdata_q      <= rdata_d;
            pass_err_q   <= pass_err_d;
            pass_q       <= pass_d;
            timeout_q    <= timeout_d;
            err_count_q  <= err_count_d;
            pass_count_q <= pass_count_d;
            ferr_addr_q  <= ferr_addr_d;
            ferr_data_q  <= ferr_data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        pat_d        = pat_q;
        wait_d       = '0;
        rdata_d      = rdata_q;
        pass_err_d   = pass_err_q;
        pass_d       = pass_q;
        timeout_d    = timeout_q;
        err_count_d  = err_count_q;
        pass_count_d = pass_count_q;
        ferr_addr_d  = ferr_addr_q;
        ferr_data_d  = ferr_data_q;
        lfsr_step    = 1'b0;
        lfsr_reseed  = 1'b0;

        // Accept states wait for ready low, complete states for ready high
        waiting  = state_q inside {ST_WR_ACC, ST_WR_CPL, ST_RD_ACC, ST_RD_CPL};
        progress = (state_q inside {ST_WR_ACC, ST_RD_ACC}) ? !mem_ready : mem_ready;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_WR_ISSUE;
                    index_d     = '0;
                    pat_d       = pattern_sel;
                    lfsr_reseed = 1'b1;
                    pass_err_d  = 1'b0;
                    timeout_d   = 1'b0;
                    err_count_d = '0;
                    ferr_addr_d = '0;
                    ferr_data_d = '0;
                end
            end
            ST_WR_ISSUE: if (mem_ready) state_d = ST_WR_ACC;
            ST_WR_ACC:   if (!mem_ready) state_d = ST_WR_CPL;
            ST_WR_CPL: begin
                if (mem_ready) begin
                    lfsr_step = 1'b1;
                    if (index_q == LAST_IDX) begin
                        index_d     = '0;
                        lfsr_reseed = 1'b1;
                        state_d     = ST_RD_ISSUE;
                    end else begin
                        index_d = index_q + 1'b1;
                        state_d = ST_WR_ISSUE;
                    end
                end
            end
            ST_RD_ISSUE: if (mem_ready) state_d = ST_RD_ACC;
            ST_RD_ACC:   if (!mem_ready) state_d = ST_RD_CPL;
            ST_RD_CPL: begin
                if (mem_ready) begin
                    rdata_d = mem_data_out;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                lfsr_step = 1'b1;
                if (rdata_q != expected) begin
                    pass_err_d = 1'b1;
                    if (err_count_q == 16'd0) begin
                        ferr_addr_d = cur_addr;
                        ferr_data_d = rdata_q;
                    end
                    if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
                end
                if (index_q == LAST_IDX) begin
                    state_d = ST_FINISH;
                end else begin
                    index_d = index_q + 1'b1;
                    state_d = ST_RD_ISSUE;
                end
            end
            ST_FINISH: begin
                pass_count_d = pass_count_q + 16'd1;
                pass_d       = !pass_err_q && !timeout_q;
                if (loop && !timeout_q) begin
                    state_d     = ST_WR_ISSUE;
                    index_d     = '0;
                    lfsr_reseed = 1'b1;
                    pass_err_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Watchdog on controller handshakes; an expiry aborts the pass
        if (waiting && !progress) begin
            if (wait_q == TW'(TIMEOUT - 1)) begin
                timeout_d = 1'b1;
                state_d   = ST_FINISH;
            end else begin
                wait_d = wait_q + 1'b1;
            end
        end
    end

    // Strobes are combinational on mem_ready so they are never high while the controller is busy
    always_comb begin
        mem_write_strb = (state_q == ST_WR_ISSUE) && mem_ready;
        mem_read_strb  = (state_q == ST_RD_ISSUE) && mem_ready;
        busy           = state_q != ST_IDLE;
        done           = state_q == ST_FINISH;
        mem_addr       = busy ? cur_addr : '0;
        mem_data_in    = (state_q inside {ST_WR_ISSUE, ST_WR_ACC, ST_WR_CPL}) ? expected : '0;
    end

    assign pass           = pass_q;
    assign timeout        = timeout_q;
    assign err_count      = err_count_q;
    assign first_err_addr = ferr_addr_q;
    assign first_err_data = ferr_data_q;
    assign pass_count     = pass_count_q;

endmodule

// File: tb/tb_psram_test_seq.sv
// tb/tb_psram_test_seq.sv - self-checking bench for psram_test_seq
module tb_psram_test_seq;

    typedef struct {
        logic [23:0] a;
        logic [15:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic        loop = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic        mem_ready = 1'b1;
    logic [15:0] mem_data_out = '0;

    logic [23:0] addr0, addr1, ferr_a0, ferr_a1;
    logic        rd0, rd1, wr0, wr1;
    logic [15:0] wd0, wd1, ferr_d0, ferr_d1, errc0, errc1, pcnt0, pcnt1;
    logic        busy0, busy1, done0, done1, pass0, pass1, to0, to1;

    int  n_assert = 0;
    int  n_fail = 0;
    bit  sel = 0;
    bit  corrupt_en = 0, alias_en = 0, hang_en = 0;
    wr_t exp_q[$];
    logic [15:0] word17 = '0;

    psram_test_seq #(.DEPTH_LOG2(4)) dut0 (
        .clk(clk), .reset(rst), .start(start0), .loop(loop), .pattern_sel(pattern_sel),
        .mem_ready(mem_ready), .mem_data_out(mem_data_out), .mem_addr(addr0),
        .mem_read_strb(rd0), .mem_write_strb(wr0), .mem_data_in(wd0), .busy(busy0),
        .done(done0), .pass(pass0), .timeout(to0), .err_count(errc0),
        .first_err_addr(ferr_a0), .first_err_data(ferr_d0), .pass_count(pcnt0)
    );

    psram_test_seq #(.DEPTH_LOG2(5)) dut1 (
        .clk(clk), .reset(rst), .start(start1), .loop(loop), .pattern_sel(pattern_sel),
        .mem_ready(mem_ready), .mem_data_out(mem_data_out), .mem_addr(addr1),
        .mem_read_strb(rd1), .mem_write_strb(wr1), .mem_data_in(wd1), .busy(busy1),
        .done(done1), .pass(pass1), .timeout(to1), .err_count(errc1),
        .first_err_addr(ferr_a1), .first_err_data(ferr_d1), .pass_count(pcnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic [15:0] exp_word(input int pat, input int i);
        logic [15:0] s;
        s = 16'hACE1;
        case (pat)
            0: return 16'(i);
            1: return ~16'(i);
            2: return 16'(1) << (i % 16);
            default: begin
                for (int k = 0; k < i; k++) s = lfsr_adv(s);
                return s;
            end
        endcase
    endfunction

    task automatic push_pass(input int n, input int pat);
        wr_t w;
        for (int i = 0; i < n; i++) begin
            w.a = 24'(i);
            w.d = exp_word(pat, i);
            exp_q.push_back(w);
        end
    endtask

    // Controller model: ready falls after a strobe, returns 20 cycles later
    logic        wr_any, rd_any;
    logic [23:0] m_addr;
    logic [15:0] m_wdata, rbuf;
    logic [15:0] mem [64];
    int          cnt = 0;
    bit          stuck = 0;

    assign wr_any  = wr0 | wr1;
    assign rd_any  = rd0 | rd1;
    assign m_addr  = sel ? addr1 : addr0;
    assign m_wdata = sel ? wd1 : wd0;

    function automatic logic [5:0] map(input logic [23:0] a);
        return (alias_en && a[5:0] == 6'd7) ? 6'd6 : a[5:0];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mem_ready <= 1'b1;
            cnt       <= 0;
            stuck     <= 1'b0;
        end else if (wr_any) begin
            mem[map(m_addr)] <= m_wdata;
            mem_ready        <= 1'b0;
            cnt              <= 20;
            stuck            <= hang_en;
        end else if (rd_any) begin
            rbuf      <= mem[map(m_addr)] ^ ((corrupt_en && m_addr == 24'd5) ? 16'h0008 : 16'h0000);
            mem_ready <= 1'b0;
            cnt       <= 20;
        end else if (!mem_ready && !stuck) begin
            if (cnt == 1) begin
                mem_ready    <= 1'b1;
                mem_data_out <= rbuf;
            end
            cnt <= cnt - 1;
        end
    end

    // Write scoreboard and strobe rules, sampled mid-cycle
    always @(negedge clk) begin
        wr_t e;
        if (wr_any || rd_any) begin
            chk("strb_ready", mem_ready, 1);
            chk("strb_excl", $countones({wr0, rd0, wr1, rd1}), 1);
        end
        if (wr_any) begin
            if (sel && m_addr == 24'd17) word17 = m_wdata;
            if (exp_q.size() == 0) begin
                chk("wr_unexpected", m_addr, 24'hFFFFFF);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", m_addr, e.a);
                chk("wr_data", m_wdata, e.d);
            end
        end
    end

    task automatic wait_done(input bit which, input int budget, output int cyc);
        bit ok;
        ok  = 0;
        cyc = 0;
        while (!ok && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if ((which ? done1 : done0) === 1'b1) ok = 1;
        end
        chk("done_seen", ok, 1);
    endtask

    task automatic pulse_start(input bit which, input logic [1:0] pat);
        pattern_sel = pat;
        if (which) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    initial begin
        int  cyc;
        bit  seen;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_strb", {rd0, wr0}, 0);
        chk("rst_addr", addr0, 0);
        chk("rst_cnts", {errc0, pcnt0}, 0);
        chk("rst_flags", {pass0, to0}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Pattern 0, clean pass
        sel = 0;
        push_pass(16, 0);
        pulse_start(0, 2'd0);
        chk("p0_busy", busy0, 1);
        wait_done(0, 3000, cyc);
        @(negedge clk);
        chk("p0_pass", pass0, 1);
        chk("p0_err", errc0, 0);
        chk("p0_pcnt", pcnt0, 1);
        chk("p0_idle", busy0, 0);
        chk("p0_sb_empty", exp_q.size(), 0);

        // Pattern 1, bit 3 of word 5 corrupted on read
        corrupt_en = 1;
        push_pass(16, 1);
        pulse_start(0, 2'd1);
        wait_done(0, 3000, cyc);
        @(negedge clk);
        corrupt_en = 0;
        chk("p1_err", errc0, 1);
        chk("p1_ferr_addr", ferr_a0, 5);
        chk("p1_ferr_data", ferr_d0, 16'hFFF2);
        chk("p1_pass", pass0, 0);
        chk("p1_pcnt", pcnt0, 2);

        // Pattern 3, words 6 and 7 alias in the model
        alias_en = 1;
        push_pass(16, 3);
        pulse_start(0, 2'd3);
        wait_done(0, 3000, cyc);
        @(negedge clk);
        alias_en = 0;
        chk("p3_err", errc0, 1);
        chk("p3_ferr_addr", ferr_a0, 6);
        chk("p3_ferr_data", ferr_d0, exp_word(3, 7));
        chk("p3_pass", pass0, 0);
        chk("p3_sb_empty", exp_q.size(), 0);

        // Pattern 2 looping on the 32-word instance
        sel = 1;
        loop = 1'b1;
        push_pass(32, 2);
        push_pass(32, 2);
        push_pass(32, 2);
        pulse_start(1, 2'd2);
        wait_done(1, 3000, cyc);
        @(negedge clk);
        chk("lp_pcnt1", pcnt1, 1);
        chk("lp_busy1", busy1, 1);
        chk("lp_word17", word17, 16'h0002);
        wait_done(1, 3000, cyc);
        @(negedge clk);
        chk("lp_pcnt2", pcnt1, 2);
        chk("lp_busy2", busy1, 1);
        loop = 1'b0;
        wait_done(1, 3000, cyc);
        @(negedge clk);
        chk("lp_pcnt3", pcnt1, 3);
        chk("lp_pass", pass1, 1);
        chk("lp_idle", busy1, 0);
        chk("lp_sb_empty", exp_q.size(), 0);

        // Controller hangs after the first write
        sel = 0;
        hang_en = 1;
        loop = 1'b1;
        push_pass(16, 0);
        pulse_start(0, 2'd0);
        wait_done(0, 6000, cyc);
        @(negedge clk);
        loop = 1'b0;
        hang_en = 0;
        exp_q.delete();
        chk("to_latency", cyc >= 4095, 1);
        chk("to_flag", to0, 1);
        chk("to_pass", pass0, 0);
        chk("to_idle", busy0, 0);
        chk("to_pcnt", pcnt0, 4);

        // Reset in the middle of the read phase
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        push_pass(16, 0);
        pulse_start(0, 2'd0);
        seen = 0;
        for (int c = 0; c < 3000 && !seen; c++) begin
            @(negedge clk);
            if (rd0 === 1'b1) seen = 1;
        end
        chk("mid_rd_seen", seen, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_strb", {rd0, wr0}, 0);
        chk("mid_rst_busy", busy0, 0);
        chk("mid_rst_pcnt", pcnt0, 0);
        chk("mid_rst_flags", {pass0, to0, done0}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        push_pass(16, 0);
        pulse_start(0, 2'd0);
        wait_done(0, 3000, cyc);
        @(negedge clk);
        chk("post_pass", pass0, 1);
        chk("post_err", errc0, 0);
        chk("post_pcnt", pcnt0, 1);
        chk("post_sb_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
